// File: rtl/dendrite_cfg_loader_if.sv
// Host write / load-control port and chain-head outputs
// of the dendrite configuration loader.
interface dendrite_cfg_loader_if #(
  parameter int NUM_DENDRITES = 4,
  parameter int WORD_LENGTH   = 16
);
  localparam int AW = $clog2(2*NUM_DENDRITES);

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WORD_LENGTH-1:0] wr_data;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   wr_err;
  logic [WORD_LENGTH-1:0] cfg_data;
  logic                   cfg_data_clk;
  logic                   dendrite_hold;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, wr_err,
    input  cfg_data, cfg_data_clk, dendrite_hold
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, wr_err,
    output cfg_data, cfg_data_clk, dendrite_hold
  );
endinterface

// File: rtl/dendrite_cfg_loader.sv
// Shadow E_l/tau_mem register file that serialises its image
// onto the daisy-chained dendrite config chain.
module dendrite_cfg_loader #(
  parameter int NUM_DENDRITES = 4,
  parameter int WORD_LENGTH   = 16,
  parameter int HALF_DIV      = 2
) (
  input logic clk,
  input logic reset,
  dendrite_cfg_loader_if.slave bus
);
  localparam int STAGES_PER_DENDRITE = 3;
  localparam int L  = STAGES_PER_DENDRITE*NUM_DENDRITES;
  localparam int AW = $clog2(2*NUM_DENDRITES);
  localparam int KW = $clog2(L);
  localparam int PW = $clog2(HALF_DIV+1);
  localparam int DW =
    (NUM_DENDRITES > 1) ? $clog2(NUM_DENDRITES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [WORD_LENGTH-1:0] el_q  [NUM_DENDRITES];
  logic [WORD_LENGTH-1:0] tau_q [NUM_DENDRITES];

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          ph_q, ph_d;
  logic [KW-1:0]          k_q, k_d;
  logic [DW-1:0]          dix_q, dix_d;
  logic [1:0]             r_q, r_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   dclk_q, dclk_d;
  logic                   err_q, err_d;

  logic [AW:0]            addr_x;
  logic                   wr_ok;
  logic [DW-1:0]          d_n;
  logic [1:0]             r_n;
  logic [WORD_LENGTH-1:0] w_n;
  logic                   ph_end;

  assign addr_x = {1'b0, bus.wr_addr};
  assign wr_ok  = bus.wr_en && (state_q == S_IDLE) &&
                  (addr_x < (AW+1)'(2*NUM_DENDRITES));
  assign err_d  = bus.wr_en && !wr_ok;
  assign ph_end = (ph_q == PW'(HALF_DIV-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < NUM_DENDRITES; d++) begin
        el_q[d]  <= '0;
        tau_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < NUM_DENDRITES; d++) begin
        if (wr_ok && addr_x == (AW+1)'(2*d))
          el_q[d] <= bus.wr_data;
        if (wr_ok && addr_x == (AW+1)'(2*d+1))
          tau_q[d] <= bus.wr_data;
      end
    end
  end

  // Walk the target stage downwards: r cycles 2,1,0 per dendrite.
  always_comb begin
    r_n = (r_q == 2'd0) ? 2'd2 : r_q - 2'd1;
    d_n = (r_q == 2'd0) ? dix_q - DW'(1) : dix_q;
    w_n = '0;
    for (int d = 0; d < NUM_DENDRITES; d++) begin
      if (d_n == DW'(d)) begin
        if (r_n == 2'd1)
          w_n = tau_q[d];
        else if (r_n == 2'd0)
          w_n = el_q[d];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    k_d     = k_q;
    dix_d   = dix_q;
    r_d     = r_q;
    data_d  = data_q;
    dclk_d  = dclk_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOW;
          ph_d    = '0;
          k_d     = '0;
          dix_d   = DW'(NUM_DENDRITES-1);
          r_d     = 2'd2;
          data_d  = '0;
          dclk_d  = 1'b0;
        end
      end
      S_LOW: begin
        if (ph_end) begin
          ph_d    = '0;
          state_d = S_HIGH;
          dclk_d  = 1'b1;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_HIGH: begin
        if (ph_end) begin
          ph_d   = '0;
          dclk_d = 1'b0;
          if (k_q == KW'(L-1)) begin
            state_d = S_FIN;
            data_d  = '0;
          end else begin
            state_d = S_LOW;
            k_d     = k_q + KW'(1);
            dix_d   = d_n;
            r_d     = r_n;
            data_d  = w_n;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      k_q     <= '0;
      dix_q   <= '0;
      r_q     <= '0;
      data_q  <= '0;
      dclk_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      k_q     <= k_d;
      dix_q   <= dix_d;
      r_q     <= r_d;
      data_q  <= data_d;
      dclk_q  <= dclk_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy = (state_q == S_LOW) ||
                    (state_q == S_HIGH);
  assign bus.done          = (state_q == S_FIN);
  assign bus.dendrite_hold = bus.busy;
  assign bus.wr_err        = err_q;
  assign bus.cfg_data      = data_q;
  assign bus.cfg_data_clk  = dclk_q;
endmodule
